// File: rtl/edit_mem_buf_free_mgr_if.sv
// Handshake bundle for the edit-memory buffer free manager: read-count set
// stream, port release stream, freed-pointer output and error pulses.
interface edit_mem_buf_free_mgr_if #(
    parameter int BPTR_NBITS    = 8,
    parameter int RC_NBITS      = 4,
    parameter int PORT_ID_NBITS = 3
);
    logic                     read_count_valid;
    logic [BPTR_NBITS-1:0]    read_count_buf_ptr;
    logic [RC_NBITS-1:0]      read_count;
    logic [PORT_ID_NBITS-1:0] read_count_port_id;
    logic                     rel_valid;
    logic [BPTR_NBITS-1:0]    rel_buf_ptr;
    logic                     free_valid;
    logic [BPTR_NBITS-1:0]    free_buf_ptr;
    logic                     free_ready;
    logic                     err_rc_ovf;
    logic                     err_rel_ovf;
    logic                     err_underflow;

    modport master (
        output read_count_valid, read_count_buf_ptr, read_count, read_count_port_id,
        output rel_valid, rel_buf_ptr, free_ready,
        input  free_valid, free_buf_ptr, err_rc_ovf, err_rel_ovf, err_underflow
    );

    modport slave (
        input  read_count_valid, read_count_buf_ptr, read_count, read_count_port_id,
        input  rel_valid, rel_buf_ptr, free_ready,
        output free_valid, free_buf_ptr, err_rc_ovf, err_rel_ovf, err_underflow
    );
endinterface

// File: rtl/edit_mem_buf_free_mgr.sv
// Per-buffer outstanding-read counter: SETs load a count, releases decrement it,
// and buffers reaching zero are queued to the free-buffer pool in order.
module edit_mem_buf_free_mgr #(
    parameter int BPTR_NBITS      = 8,
    parameter int RC_NBITS        = 4,
    parameter int IN_DEPTH_NBITS  = 3,
    parameter int OUT_DEPTH_NBITS = 4
) (
    input logic clk,
    input logic rst,
    edit_mem_buf_free_mgr_if.slave bus
);
    localparam int IN_DEPTH  = 1 << IN_DEPTH_NBITS;
    localparam int OUT_DEPTH = 1 << OUT_DEPTH_NBITS;
    localparam int TBL_DEPTH = 1 << BPTR_NBITS;
    localparam int ICW       = IN_DEPTH_NBITS + 1;
    localparam int OCW       = OUT_DEPTH_NBITS + 1;
    localparam int FLW       = OUT_DEPTH_NBITS + 2;

    typedef logic [BPTR_NBITS-1:0] ptr_t;
    typedef logic [RC_NBITS-1:0]   rc_t;

    ptr_t rc_ptr_mem [IN_DEPTH];
    rc_t  rc_cnt_mem [IN_DEPTH];
    ptr_t rel_mem    [IN_DEPTH];
    ptr_t out_mem    [OUT_DEPTH];
    rc_t  tbl        [TBL_DEPTH];

    logic [IN_DEPTH_NBITS-1:0]  rc_wr, rc_rd, rel_wr, rel_rd;
    logic [ICW-1:0]             rc_used, rel_used;
    logic [OUT_DEPTH_NBITS-1:0] out_wr, out_rd, out_rd_nxt;
    logic [OCW-1:0]             out_used, out_used_nxt;
    logic [FLW-1:0]             occupancy;

    logic rc_full, rel_full, rc_push, rel_push, rc_pop, rel_pop;
    logic rr_rel, stall, pick_rel, pop;
    logic s1_valid, s1_is_set, s2_valid, s2_is_set;
    ptr_t s0_ptr, s1_ptr, s2_ptr, head_nxt, free_buf_ptr_q;
    rc_t  s1_cnt, s2_cnt, s1_cur, s2_cur, s2_new, ram_rdata;
    logic s2_under, wr_en, free_push, out_pop;
    logic free_valid_q, err_rc_ovf_q, err_rel_ovf_q, err_underflow_q;

    assign rc_full  = rc_used == ICW'(IN_DEPTH);
    assign rel_full = rel_used == ICW'(IN_DEPTH);
    assign rc_push  = bus.read_count_valid && !rc_full;
    assign rel_push = bus.rel_valid && !rel_full;

    // Ops already popped count against output space so the free FIFO can never overflow.
    assign occupancy = FLW'(out_used) + FLW'(s1_valid) + FLW'(s2_valid);
    assign stall     = occupancy >= FLW'(OUT_DEPTH - 2);
    assign pick_rel  = (rel_used != '0) && (rr_rel || rc_used == '0);
    assign pop       = !stall && (rel_used != '0 || rc_used != '0);
    assign rel_pop   = pop && pick_rel;
    assign rc_pop    = pop && !pick_rel;
    assign s0_ptr    = pick_rel ? rel_mem[rel_rd] : rc_ptr_mem[rc_rd];

    assign s1_cur    = (wr_en && s2_ptr == s1_ptr) ? s2_new : ram_rdata;
    assign s2_under  = s2_valid && !s2_is_set && s2_cur == '0;
    assign s2_new    = s2_is_set ? s2_cnt : s2_cur - RC_NBITS'(1);
    assign wr_en     = s2_valid && !s2_under;
    assign free_push = wr_en && s2_new == '0;
    assign out_pop   = free_valid_q && bus.free_ready;

    always_ff @(posedge clk) begin
        if (rc_push) begin
            rc_ptr_mem[rc_wr] <= bus.read_count_buf_ptr;
            rc_cnt_mem[rc_wr] <= bus.read_count;
        end
        if (rel_push)
            rel_mem[rel_wr] <= bus.rel_buf_ptr;
        if (free_push)
            out_mem[out_wr] <= s2_ptr;
    end

    // Count table: write-first so an op read in the writeback cycle of an older op sees it.
    always_ff @(posedge clk) begin
        if (wr_en)
            tbl[s2_ptr] <= s2_new;
        ram_rdata <= (wr_en && s2_ptr == s0_ptr) ? s2_new : tbl[s0_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc_wr         <= '0;
            rc_rd         <= '0;
            rc_used       <= '0;
            rel_wr        <= '0;
            rel_rd        <= '0;
            rel_used      <= '0;
            err_rc_ovf_q  <= 1'b0;
            err_rel_ovf_q <= 1'b0;
        end else begin
            if (rc_push)  rc_wr  <= rc_wr + IN_DEPTH_NBITS'(1);
            if (rc_pop)   rc_rd  <= rc_rd + IN_DEPTH_NBITS'(1);
            if (rel_push) rel_wr <= rel_wr + IN_DEPTH_NBITS'(1);
            if (rel_pop)  rel_rd <= rel_rd + IN_DEPTH_NBITS'(1);
            rc_used       <= rc_used + ICW'(rc_push) - ICW'(rc_pop);
            rel_used      <= rel_used + ICW'(rel_push) - ICW'(rel_pop);
            err_rc_ovf_q  <= bus.read_count_valid && rc_full;
            err_rel_ovf_q <= bus.rel_valid && rel_full;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_rel          <= 1'b1;
            s1_valid        <= 1'b0;
            s1_is_set       <= 1'b0;
            s1_ptr          <= '0;
            s1_cnt          <= '0;
            s2_valid        <= 1'b0;
            s2_is_set       <= 1'b0;
            s2_ptr          <= '0;
            s2_cnt          <= '0;
            s2_cur          <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            if (pop) rr_rel <= !pick_rel;
            s1_valid        <= pop;
            s1_is_set       <= !pick_rel;
            s1_ptr          <= s0_ptr;
            s1_cnt          <= rc_cnt_mem[rc_rd];
            s2_valid        <= s1_valid;
            s2_is_set       <= s1_is_set;
            s2_ptr          <= s1_ptr;
            s2_cnt          <= s1_cnt;
            s2_cur          <= s1_cur;
            err_underflow_q <= s2_under;
        end
    end

    // The head register is refilled from storage, or straight from S2 when the FIFO would otherwise be empty.
    always_comb begin
        out_used_nxt = out_used + OCW'(free_push) - OCW'(out_pop);
        out_rd_nxt   = out_pop ? out_rd + OUT_DEPTH_NBITS'(1) : out_rd;
        head_nxt     = free_buf_ptr_q;
        if (out_used - OCW'(out_pop) == '0) begin
            if (free_push)
                head_nxt = s2_ptr;
        end else begin
            head_nxt = out_mem[out_rd_nxt];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_wr         <= '0;
            out_rd         <= '0;
            out_used       <= '0;
            free_valid_q   <= 1'b0;
            free_buf_ptr_q <= '0;
        end else begin
            if (free_push) out_wr <= out_wr + OUT_DEPTH_NBITS'(1);
            out_rd         <= out_rd_nxt;
            out_used       <= out_used_nxt;
            free_valid_q   <= out_used_nxt != '0;
            free_buf_ptr_q <= head_nxt;
        end
    end

    assign bus.free_valid    = free_valid_q;
    assign bus.free_buf_ptr  = free_buf_ptr_q;
    assign bus.err_rc_ovf    = err_rc_ovf_q;
    assign bus.err_rel_ovf   = err_rel_ovf_q;
    assign bus.err_underflow = err_underflow_q;
endmodule
